// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) that stalls the pipeline while busy.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration loop.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     araw_q, araw_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   fin_q, fin_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH+1:0]     shifted;
  logic [WIDTH+1:0]     diff;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    araw_d   = araw_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    result_d = result_q;

    // Partial remainder shifted left with the next dividend bit; the top bit of diff is the borrow.
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {2'b00, dvs_q};

    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          araw_d  = a;
          dvs_d   = abs_val(b, signed_div);
          quo_d   = abs_val(a, signed_div);
          rem_d   = '0;
          qneg_d  = signed_div && (a[WIDTH-1] != b[WIDTH-1]);
          rneg_d  = signed_div && a[WIDTH-1];
          dz_d    = (b == '0);
          cnt_d   = '0;
          state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (b == '0) begin
            fin_d   = {a, {WIDTH{1'b1}}};
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            fin_d   = dz_q ? {araw_q, {WIDTH{1'b1}}}
                           : {neg_if(rem_d[WIDTH-1:0], rneg_q), neg_if(quo_d, qneg_q)};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!annul) result_d = fin_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      araw_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      fin_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      araw_q   <= araw_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      result_q <= result_d;
    end
  end

  // The finished value is already in fin_q, so it is visible in the ready cycle itself.
  assign stall  = ((state_q == IDLE) && start && !annul) || (state_q == BUSY);
  assign ready  = (state_q == DONE) && !annul;
  assign result = ready ? fin_q : result_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: table vectors, hand-written control sequences and random operands vs a model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall;
  logic        ready;
  logic [63:0] result;

  int nvec = 0;
  int nmis = 0;
  logic [63:0] last_res;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .stall(stall), .ready(ready), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
    if (y == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Drives start in the current cycle (caller is at a negedge), then drops it after the edge.
  task automatic launch_now(input logic [31:0] ia, input logic [31:0] ib, input logic is);
    a = ia; b = ib; signed_div = is; start = 1'b1; annul = 1'b0;
    #1 check("stall_launch", stall, 1);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic launch(input logic [31:0] ia, input logic [31:0] ib, input logic is);
    @(negedge clk);
    launch_now(ia, ib, is);
  endtask

  task automatic wait_ready(input int elat, output logic [63:0] res);
    int lat = -1;
    int stall_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (stall !== (k < elat)) stall_bad++;
      if (ready) begin
        lat = k;
        break;
      end
    end
    res = result;
    check("latency", lat, elat);
    check("stall_window", stall_bad, 0);
    @(negedge clk);
    check("ready_one_cycle", ready, 0);
    check("result_hold", result, res);
  endtask

  vec_t tbl[11];

  initial begin
    logic [63:0] res;
    logic [31:0] ra, rb;
    logic        rs;
    int          pulses;
    logic [63:0] pulse_res;

    tbl[0]  = '{"divu_100_7",      32'd100,        32'd7,          1'b0, {32'd2,          32'd14}};
    tbl[1]  = '{"div_m7_2",        32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
    tbl[2]  = '{"div_ovf",         32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0,          32'h8000_0000}};
    tbl[3]  = '{"divu_b0",         32'h1234_5678,  32'd0,          1'b0, {32'h1234_5678,  32'hFFFF_FFFF}};
    tbl[4]  = '{"div_b0",          32'h1234_5678,  32'd0,          1'b1, {32'h1234_5678,  32'hFFFF_FFFF}};
    tbl[5]  = '{"divu_max_1",      32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0,          32'hFFFF_FFFF}};
    tbl[6]  = '{"div_7_m2",        32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1,          32'hFFFF_FFFD}};
    tbl[7]  = '{"div_m7_m2",       32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, {32'hFFFF_FFFF,  32'd3}};
    tbl[8]  = '{"divu_5_10",       32'd5,          32'd10,         1'b0, {32'd5,          32'd0}};
    tbl[9]  = '{"divu_min_max",    32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000,  32'd0}};
    tbl[10] = '{"div_m1_b0",       32'hFFFF_FFFF,  32'd0,          1'b1, {32'hFFFF_FFFF,  32'hFFFF_FFFF}};

    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 0);
    check("reset_result", result, 64'd0);
    check("reset_stall", stall, 0);
    resetn = 1'b1;
    last_res = 64'd0;

    for (int i = 0; i < 11; i++) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].sgn);
      wait_ready(exp_lat(tbl[i].b), res);
      check(tbl[i].name, res, tbl[i].exp);
      last_res = res;
    end

    // annul during BUSY aborts with no ready pulse, then a fresh start runs to completion
    launch(32'd1000, 32'd3, 1'b0);
    pulses = 0;
    repeat (9) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    @(negedge clk);
    annul = 1'b1;
    #1 if (ready) pulses++;
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    check("abort_no_ready", pulses, 0);
    check("abort_idle_stall", stall, 0);
    check("abort_result_kept", result, last_res);
    launch_now(32'd1000, 32'd3, 1'b0);
    wait_ready(33, res);
    check("after_abort", res, {32'd1, 32'd333});
    last_res = res;

    // start while BUSY is ignored: one pulse carrying the first operation's result
    launch(32'd90, 32'd9, 1'b0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    a = 32'd7; b = 32'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pulses = 0; pulse_res = '0;
    repeat (40) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        pulse_res = result;
      end
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_result", pulse_res, {32'd0, 32'd10});
    last_res = {32'd0, 32'd10};

    // annul together with start in IDLE: nothing launches
    @(negedge clk);
    a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
    #1 check("annul_start_stall", stall, 0);
    @(posedge clk); #1 begin start = 1'b0; annul = 1'b0; end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("annul_start_no_ready", pulses, 0);
    check("annul_start_result", result, last_res);

    // annul in the DONE cycle suppresses ready and keeps the old result
    launch(32'd50, 32'd5, 1'b0);
    repeat (32) @(negedge clk);
    @(negedge clk);
    annul = 1'b1;
    #1 begin
      check("done_annul_ready", ready, 0);
      check("done_annul_result", result, last_res);
    end
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    check("done_annul_idle", stall, 0);
    check("done_annul_ready2", ready, 0);
    check("done_annul_result2", result, last_res);

    // reset mid-BUSY clears everything at once
    launch(32'd12345, 32'd11, 1'b0);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1 begin
      check("midrst_ready", ready, 0);
      check("midrst_result", result, 64'd0);
      check("midrst_stall", stall, 0);
    end
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("midrst_no_ready", pulses, 0);
    last_res = 64'd0;

    // randomized operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom_range(1, 65535);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      launch(ra, rb, rs);
      wait_ready(exp_lat(rb), res);
      check("random", res, ref_div(ra, rb, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
